gpr_wb_arbiter: RTL and testbench

- Write-side front end of the general-purpose register file.
- Merges two result sources onto the single GPR write port (wr_regwr / wr_regdst_addr / wr_data):
  - the in-order pipeline writeback, which has top priority and never stalls;
  - a multi-cycle result source (multiplier/divider, late loads) that uses a valid/ready handshake and is buffered in a small FIFO.
- Publishes a pending-write mask so decode can interlock on queued destinations.
- Requests a pipeline bubble when queued results starve.

---
 rtl/gpr_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: the pipeline writeback has priority over a FIFO of multi-cycle
// results. Also publishes a pending-destination mask and a starvation stall request.
module gpr_wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_wr_en,
  input  logic [4:0]               pipe_wr_addr,
  input  logic [31:0]              pipe_wr_data,
  input  logic                     mc_valid,
  input  logic [4:0]               mc_addr,
  input  logic [31:0]              mc_data,
  output logic                     mc_ready,
  output logic                     wr_regwr,
  output logic [4:0]               wr_regdst_addr,
  output logic [31:0]              wr_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     wb_stall_req
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 8;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          regwr_q, regwr_d;
  logic [4:0]    oaddr_q, oaddr_d;
  logic [31:0]   odata_q, odata_d;

  logic pipe_eff;
  logic push;
  logic pop;

  // Ready is a function of the registered count only, so a same-cycle pop never frees a slot.
  assign mc_ready = rst_n && (count_q < CW'(DEPTH));
  assign pipe_eff = pipe_wr_en && (pipe_wr_addr != 5'd0);
  assign push     = mc_valid && mc_ready && (mc_addr != 5'd0);
  assign pop      = !pipe_eff && (count_q != '0);

  assign wr_regwr       = regwr_q;
  assign wr_regdst_addr = oaddr_q;
  assign wr_data        = odata_q;
  assign fifo_count     = count_q;
  assign wb_stall_req   = stall_q;

  // One-hot OR of every occupied entry's destination.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        pend_mask[addr_q[rptr_q + AW'(i)]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    stall_d  = stall_q;
    regwr_d  = 1'b0;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (pipe_eff) begin
      regwr_d = 1'b1;
      oaddr_d = pipe_wr_addr;
      odata_d = pipe_wr_data;
    end else if (pop) begin
      regwr_d = 1'b1;
      oaddr_d = addr_q[rptr_q];
      odata_d = data_q[rptr_q];
    end

    // A non-empty FIFO without a pop means the pipeline blocked the head this cycle.
    if (pop || (count_q == '0)) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
      if (starve_d == SW'(STARVE_LIMIT)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      regwr_q  <= 1'b0;
      oaddr_q  <= '0;
      odata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      regwr_q  <= regwr_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= mc_addr;
      data_q[wptr_q] <= mc_data;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter (DEPTH=4, STARVE_LIMIT=8) with hand-computed expectations.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        mc_valid;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        wr_regwr;
  logic [4:0]  wr_regdst_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;
  logic        wb_stall_req;

  int checks;
  int failures;

  gpr_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_wr_en     (pipe_wr_en),
    .pipe_wr_addr   (pipe_wr_addr),
    .pipe_wr_data   (pipe_wr_data),
    .mc_valid       (mc_valid),
    .mc_addr        (mc_addr),
    .mc_data        (mc_data),
    .mc_ready       (mc_ready),
    .wr_regwr       (wr_regwr),
    .wr_regdst_addr (wr_regdst_addr),
    .wr_data        (wr_data),
    .pend_mask      (pend_mask),
    .fifo_count     (fifo_count),
    .wb_stall_req   (wb_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".regwr"}, 32'(wr_regwr), 32'(en));
    chk({tag, ".addr"}, 32'(wr_regdst_addr), 32'(a));
    chk({tag, ".data"}, wr_data, d);
  endtask

  task automatic chk_st(input string tag, input int cnt, input logic [31:0] pend,
                        input logic rdy, input logic stall);
    chk({tag, ".count"}, 32'(fifo_count), cnt);
    chk({tag, ".pend"}, pend_mask, pend);
    chk({tag, ".ready"}, 32'(mc_ready), 32'(rdy));
    chk({tag, ".stall"}, 32'(wb_stall_req), 32'(stall));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    pipe_wr_en   = 1'b0;
    pipe_wr_addr = 5'd0;
    pipe_wr_data = 32'h0;
    mc_valid     = 1'b0;
    mc_addr      = 5'd0;
    mc_data      = 32'h0;

    // Reset state
    tick();
    tick();
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk_st("rst", 0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.ready", 32'(mc_ready), 32'd1);
    tick();
    chk_wr("idle", 1'b0, 5'd0, 32'h0);
    chk_st("idle", 0, 32'h0, 1'b1, 1'b0);

    // Plain pipeline write, then hold of address/data when idle
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'h1234;
    tick();
    chk_wr("pipe_r5", 1'b1, 5'd5, 32'h0000_1234);
    pipe_wr_en = 1'b0;
    tick();
    chk_wr("pipe_hold", 1'b0, 5'd5, 32'h0000_1234);

    // Two mc results on an idle pipeline
    mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'hA;
    tick();
    chk_wr("mc_r7_acc", 1'b0, 5'd5, 32'h0000_1234);
    chk_st("mc_r7_acc", 1, 32'h0000_0080, 1'b1, 1'b0);
    mc_addr = 5'd8; mc_data = 32'hB;
    tick();
    chk_wr("mc_r7_wr", 1'b1, 5'd7, 32'hA);
    chk_st("mc_r7_wr", 1, 32'h0000_0100, 1'b1, 1'b0);
    mc_valid = 1'b0;
    tick();
    chk_wr("mc_r8_wr", 1'b1, 5'd8, 32'hB);
    chk_st("mc_r8_wr", 0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("mc_drained.regwr", 32'(wr_regwr), 32'd0);

    // Pipeline hogs the port while the FIFO fills and starves
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3; pipe_wr_data = 32'h33;
    mc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mc_addr = 5'(10 + i);
      mc_data = 32'(32'h100 + i);
      tick();
    end
    chk_wr("fill", 1'b1, 5'd3, 32'h33);
    chk_st("fill", 4, 32'h0000_3C00, 1'b0, 1'b0);
    mc_addr = 5'd14; mc_data = 32'h1E;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("starve_pre.stall", 32'(wb_stall_req), 32'd0);
      chk("starve_pre.count", 32'(fifo_count), 32'd4);
    end
    tick();
    chk_wr("starved", 1'b1, 5'd3, 32'h33);
    chk_st("starved", 4, 32'h0000_3C00, 1'b0, 1'b1);

    // Drain; first pop cannot coincide with an accept because ready was low
    pipe_wr_en = 1'b0;
    tick();
    chk_wr("drain0", 1'b1, 5'd10, 32'h100);
    chk_st("drain0", 3, 32'h0000_3800, 1'b1, 1'b0);
    tick();
    mc_valid = 1'b0;
    chk_wr("drain1", 1'b1, 5'd11, 32'h101);
    chk_st("drain1", 3, 32'h0000_7000, 1'b1, 1'b0);
    tick();
    chk_wr("drain2", 1'b1, 5'd12, 32'h102);
    chk_st("drain2", 2, 32'h0000_6000, 1'b1, 1'b0);
    tick();
    chk_wr("drain3", 1'b1, 5'd13, 32'h103);
    chk_st("drain3", 1, 32'h0000_4000, 1'b1, 1'b0);
    tick();
    chk_wr("drain4", 1'b1, 5'd14, 32'h1E);
    chk_st("drain4", 0, 32'h0, 1'b1, 1'b0);
    tick();
    chk_wr("drained", 1'b0, 5'd14, 32'h1E);

    // Register 0 is filtered on both sources
    mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hDEAD;
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'hBEEF;
    #1;
    chk("r0.ready", 32'(mc_ready), 32'd1);
    tick();
    chk_wr("r0", 1'b0, 5'd14, 32'h1E);
    chk_st("r0", 0, 32'h0, 1'b1, 1'b0);
    mc_valid = 1'b0; pipe_wr_en = 1'b0;
    tick();

    // Reset with three entries queued and a write in flight
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd4; pipe_wr_data = 32'h44;
    mc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mc_addr = 5'(20 + i);
      mc_data = 32'(32'h200 + i);
      tick();
    end
    chk_wr("pre_rst", 1'b1, 5'd4, 32'h44);
    chk_st("pre_rst", 3, 32'h0070_0000, 1'b1, 1'b0);
    mc_valid = 1'b0; pipe_wr_en = 1'b0; rst_n = 1'b0;
    tick();
    chk_wr("mid_rst", 1'b0, 5'd0, 32'h0);
    chk_st("mid_rst", 0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst.regwr", 32'(wr_regwr), 32'd0);
      chk("post_rst.count", 32'(fifo_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
